// File: rtl/aoc_run_ctrl.sv
// aoc_run_ctrl: run controller for one puzzle-solver datapath.
//
// Buffers a puzzle input loaded byte by byte, holds the solver in reset for two
// cycles, streams the buffer into the solver over a valid/ready handshake, waits
// for the solver's end-of-input indication and captures the final sum and the
// number of newline bytes the solver accepted. Results are held until the next
// run.
//
// Optional feature macro: AOC_RUN_AUTO_NEWLINE_EN
//   When defined, a buffer whose last byte is not 0x0A gets one extra 0x0A
//   streamed after it, so a trailing partial line is still summed.
//
// Parameters:
//   DEPTH     buffer capacity in bytes (power of two, >= 2)
//   RESULT_W  width of the solver result
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   load_valid/load_data/load_ready byte loader handshake (IDLE only)
//   start, clear                    run request, empty buffer / return to IDLE
//   sol_rst_n                       active-low solver reset
//   sol_input_valid/sol_char_in/sol_input_ready   byte stream to the solver
//   sol_result, sol_output_valid    solver sum and end-of-input indication
//   busy, done                      run in progress / result held
//   result, line_count, byte_count  captured sum, newlines streamed, buffer fill
module aoc_run_ctrl #(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned RESULT_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  input  logic [7:0]             load_data,
  output logic                   load_ready,
  input  logic                   start,
  input  logic                   clear,
  output logic                   sol_rst_n,
  output logic                   sol_input_valid,
  output logic [7:0]             sol_char_in,
  input  logic                   sol_input_ready,
  input  logic [RESULT_W-1:0]    sol_result,
  input  logic                   sol_output_valid,
  output logic                   busy,
  output logic                   done,
  output logic [RESULT_W-1:0]    result,
  output logic [31:0]            line_count,
  output logic [$clog2(DEPTH):0] byte_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [7:0] Newline = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       byte_count_q, byte_count_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                clr_cnt_q, clr_cnt_d;
  logic                guard_q, guard_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [31:0]         line_count_q, line_count_d;

  logic [7:0]          mem [DEPTH];
  logic                wr_en;
  logic [7:0]          rd_byte;
  logic [7:0]          stream_byte;
  logic [CW-1:0]       last_pos;
  logic                last_accept;

  // Buffer storage has no reset; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[byte_count_q[AW-1:0]] <= load_data;
    end
  end

  assign rd_byte  = mem[rd_ptr_q[AW-1:0]];
  assign last_pos = byte_count_q - CW'(1);

`ifdef AOC_RUN_AUTO_NEWLINE_EN
  logic [7:0] last_byte;
  logic       need_nl;

  assign last_byte = mem[last_pos[AW-1:0]];
  assign need_nl   = (last_byte != Newline);
  // rd_ptr == byte_count only happens for the appended newline slot.
  assign stream_byte = (rd_ptr_q == byte_count_q) ? Newline : rd_byte;
  assign last_accept = need_nl ? (rd_ptr_q == byte_count_q) : (rd_ptr_q == last_pos);
`else
  assign stream_byte = rd_byte;
  assign last_accept = (rd_ptr_q == last_pos);
`endif

  always_comb begin
    state_d         = state_q;
    byte_count_d    = byte_count_q;
    rd_ptr_d        = rd_ptr_q;
    clr_cnt_d       = clr_cnt_q;
    guard_d         = guard_q;
    result_d        = result_q;
    line_count_d    = line_count_q;
    wr_en           = 1'b0;
    load_ready      = 1'b0;
    sol_input_valid = 1'b0;
    sol_char_in     = 8'h00;
    busy            = 1'b0;

    case (state_q)
      StIdle: begin
        load_ready = (byte_count_q < DepthC);
        if (clear) begin
          byte_count_d = '0;
        end else begin
          if (load_valid && load_ready) begin
            wr_en        = 1'b1;
            byte_count_d = byte_count_q + CW'(1);
          end
          // Start qualifies on the fill level before this cycle's load.
          if (start && (byte_count_q != '0)) begin
            state_d      = StClear;
            clr_cnt_d    = 1'b0;
            rd_ptr_d     = '0;
            line_count_d = '0;
            result_d     = '0;
          end
        end
      end

      StClear: begin
        busy      = 1'b1;
        clr_cnt_d = 1'b1;
        if (clr_cnt_q) begin
          state_d = StStream;
        end
      end

      StStream: begin
        busy            = 1'b1;
        sol_input_valid = 1'b1;
        sol_char_in     = stream_byte;
        if (sol_input_ready) begin
          rd_ptr_d = rd_ptr_q + CW'(1);
          if ((stream_byte == Newline) && (line_count_q != 32'hFFFF_FFFF)) begin
            line_count_d = line_count_q + 32'd1;
          end
          if (last_accept) begin
            state_d = StDrain;
            guard_d = 1'b1;
          end
        end
      end

      StDrain: begin
        busy = 1'b1;
        // First DRAIN cycle ignores a stale end-of-input from the solver.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (sol_output_valid) begin
          result_d = sol_result;
          state_d  = StDone;
        end
      end

      StDone: begin
        if (clear) begin
          state_d      = StIdle;
          byte_count_d = '0;
        end else if (start) begin
          state_d      = StClear;
          clr_cnt_d    = 1'b0;
          rd_ptr_d     = '0;
          line_count_d = '0;
          result_d     = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_count_q <= '0;
      rd_ptr_q     <= '0;
      clr_cnt_q    <= 1'b0;
      guard_q      <= 1'b0;
      result_q     <= '0;
      line_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      rd_ptr_q     <= rd_ptr_d;
      clr_cnt_q    <= clr_cnt_d;
      guard_q      <= guard_d;
      result_q     <= result_d;
      line_count_q <= line_count_d;
    end
  end

  // Solver reset follows the reset input directly so it is low during reset.
  assign sol_rst_n  = ~(rst | (state_q == StClear));
  assign done       = (state_q == StDone);
  assign result     = result_q;
  assign line_count = line_count_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_aoc_run_ctrl.sv
// Bench for aoc_run_ctrl: a small behavioural solver (calibration-value sum with
// spelled digits), directed cases and randomized buffers, scoreboard-checked.
module tb_aoc_run_ctrl;

  localparam int unsigned TbDepth = 32;
  localparam int unsigned RW      = 64;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [63:0] res;
    int          lines;
    int          nbytes;
    int          due;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic                     load_valid;
  logic [7:0]               load_data;
  logic                     load_ready;
  logic                     start;
  logic                     clear;
  logic                     sol_rst_n;
  logic                     sol_input_valid;
  logic [7:0]               sol_char_in;
  logic                     sol_input_ready;
  logic [RW-1:0]            sol_result;
  logic                     sol_output_valid;
  logic                     busy;
  logic                     done;
  logic [RW-1:0]            result;
  logic [31:0]              line_count;
  logic [$clog2(TbDepth):0] byte_count;

  aoc_run_ctrl #(
    .DEPTH   (TbDepth),
    .RESULT_W(RW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .start           (start),
    .clear           (clear),
    .sol_rst_n       (sol_rst_n),
    .sol_input_valid (sol_input_valid),
    .sol_char_in     (sol_char_in),
    .sol_input_ready (sol_input_ready),
    .sol_result      (sol_result),
    .sol_output_valid(sol_output_valid),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .line_count      (line_count),
    .byte_count      (byte_count)
  );

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  exp_t  sb[$];
  string words[9] = '{"one", "two", "three", "four", "five", "six", "seven", "eight", "nine"};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic int digit_at(input bq_t l, input int i);
    if (l[i] >= 8'h30 && l[i] <= 8'h39) return int'(l[i]) - 48;
    for (int w = 0; w < 9; w++) begin
      string s;
      bit    ok;
      s  = words[w];
      ok = (i + s.len() <= l.size());
      for (int k = 0; ok && k < s.len(); k++) begin
        if (l[i+k] != s[k]) ok = 1'b0;
      end
      if (ok) return w + 1;
    end
    return -1;
  endfunction

  function automatic int calib(input bq_t l);
    int first;
    int last;
    first = -1;
    last  = -1;
    for (int i = 0; i < l.size(); i++) begin
      int d;
      d = digit_at(l, i);
      if (d >= 0) begin
        if (first < 0) first = d;
        last = d;
      end
    end
    if (first < 0) return 0;
    return 10 * first + last;
  endfunction

  task automatic ref_model(input bq_t b, output logic [63:0] r, output int l, output int n);
    bq_t s;
    bq_t ln;
    s = b;
    r = 64'd0;
    l = 0;
`ifdef AOC_RUN_AUTO_NEWLINE_EN
    if (s.size() > 0 && s[s.size()-1] != 8'h0A) s.push_back(8'h0A);
`endif
    foreach (s[i]) begin
      if (s[i] == 8'h0A) begin
        r = r + 64'(calib(ln));
        l++;
        ln.delete();
      end else begin
        ln.push_back(s[i]);
      end
    end
    n = s.size();
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t gen_buf();
    bq_t b;
    int  nl;
    nl = int'($urandom_range(1, 4));
    for (int k = 0; k < nl; k++) begin
      int ntok;
      b.push_back(8'h31 + 8'($urandom_range(0, 8)));  // every line begins with a digit
      ntok = int'($urandom_range(0, 4));
      for (int t = 0; t < ntok; t++) begin
        case ($urandom_range(0, 2))
          0: b.push_back(8'h31 + 8'($urandom_range(0, 8)));
          1: begin
            string s;
            s = words[$urandom_range(0, 8)];
            for (int j = 0; j < s.len(); j++) b.push_back(s[j]);
          end
          default: b.push_back(8'h61 + 8'($urandom_range(0, 25)));
        endcase
      end
      if (k != nl - 1 || $urandom_range(0, 3) != 0) b.push_back(8'h0A);
    end
    while (b.size() > TbDepth) void'(b.pop_back());
    return b;
  endfunction

  // ---------------- behavioural solver ----------------
  logic [63:0] sum_q;
  int          acc_bytes;
  bq_t         line_q;

  assign sol_result       = sum_q;
  assign sol_output_valid = sol_rst_n && !sol_input_valid;

  always @(posedge clk) begin
    if (!sol_rst_n) begin
      sum_q     <= 64'd0;
      acc_bytes <= 0;
      line_q.delete();
    end else if (sol_input_valid && sol_input_ready) begin
      acc_bytes <= acc_bytes + 1;
      if (sol_char_in == 8'h0A) begin
        sum_q <= sum_q + 64'(calib(line_q));
        line_q.delete();
      end else begin
        line_q.push_back(sol_char_in);
      end
    end
  end

  initial begin
    sol_input_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       sol_input_ready = 1'b1;
        1:       sol_input_ready = ~sol_input_ready;
        default: sol_input_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic       done_prev = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("line_count", 64'(line_count), 64'(e.lines));
          chk("bytes_streamed", 64'(acc_bytes), 64'(e.nbytes));
          if (e.due >= 0) chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (prev_stall && sol_input_valid) chk("char_stable", 64'(sol_char_in), 64'(prev_char));
      prev_stall = sol_input_valid && !sol_input_ready;
      prev_char  = sol_char_in;
    end else begin
      prev_stall = 1'b0;
    end
    done_prev = done;
  end

  // ---------------- stimulus tasks (entered and left 1 after a rising edge) ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic load(input bq_t d);
    foreach (d[i]) begin
      load_valid = 1'b1;
      load_data  = d[i];
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic run(input logic [63:0] r, input int l, input int n, input bit lat);
    exp_t e;
    start    = 1'b1;
    e.res    = r;
    e.lines  = l;
    e.nbytes = n;
    e.due    = lat ? cyc + n + 5 : -1;
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done within 2000 cycles");
      sb.delete();
    end
    step();
  endtask

  task automatic check_fill(input int n);
    @(negedge clk);
    chk("byte_count", 64'(byte_count), 64'(n));
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    start      = 1'b0;
    clear      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_sol_rst_n", 64'(sol_rst_n), 64'd0);
    chk("rst_valid", 64'(sol_input_valid), 64'd0);
    chk("rst_char", 64'(sol_char_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_line_count", 64'(line_count), 64'd0);
    chk("rst_byte_count", 64'(byte_count), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Single line, fixed latency T+11.
    load(s2q("1abc2\n"));
    check_fill(6);
    run(64'd12, 1, 6, 1'b1);
    wait_done();

    // Spelled digits, overlapping words.
    do_clear();
    load(s2q("two1nine\neightwo3\n"));
    run(64'd112, 2, 18, 1'b1);
    wait_done();

    // Trailing partial line.
    do_clear();
    load(s2q("7pqr\n3x"));
`ifdef AOC_RUN_AUTO_NEWLINE_EN
    run(64'd110, 2, 8, 1'b1);
`else
    run(64'd77, 1, 7, 1'b1);
`endif
    wait_done();

    // Fill to capacity and offer one more newline, which must be dropped.
    do_clear();
    check_fill(0);
    load(s2q("1abc2\n1abc2\n1abc2\n1abc2\n1abc2\n7x"));
    @(negedge clk);
    chk("full_load_ready", 64'(load_ready), 64'd0);
    chk("full_byte_count", 64'(byte_count), 64'(TbDepth));
    step();
    load(s2q("\n"));
    check_fill(TbDepth);
`ifdef AOC_RUN_AUTO_NEWLINE_EN
    run(64'd137, 6, 33, 1'b1);
`else
    run(64'd60, 5, 32, 1'b1);
`endif
    wait_done();

    // Start on an empty buffer is ignored.
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("empty_start_busy", 64'(busy), 64'd0);
    chk("empty_start_sol_rst_n", 64'(sol_rst_n), 64'd1);
    chk("empty_start_byte_count", 64'(byte_count), 64'd0);
    step();

    // Toggling ready; load bytes offered mid-run must be refused.
    load(s2q("1abc2\n"));
    rdy_mode = 1;
    run(64'd12, 1, 6, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'h0A;
    wait_done();
    load_valid = 1'b0;
    rdy_mode   = 0;
    check_fill(6);

    // Re-run from DONE: solver reset for exactly two cycles, same result.
    run(64'd12, 1, 6, 1'b1);
    @(negedge clk);
    chk("rerun_sol_rst_n_c1", 64'(sol_rst_n), 64'd0);
    chk("rerun_done_cleared", 64'(done), 64'd0);
    chk("rerun_result_cleared", result, 64'd0);
    @(negedge clk);
    chk("rerun_sol_rst_n_c2", 64'(sol_rst_n), 64'd0);
    @(negedge clk);
    chk("rerun_sol_rst_n_c3", 64'(sol_rst_n), 64'd1);
    chk("rerun_first_valid", 64'(sol_input_valid), 64'd1);
    wait_done();

    // Randomized buffers and ready patterns against the reference model.
    for (int it = 0; it < 16; it++) begin
      bq_t         b;
      logic [63:0] r;
      int          l;
      int          n;
      do_clear();
      b = gen_buf();
      load(b);
      check_fill(b.size());
      ref_model(b, r, l, n);
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      run(r, l, n, rdy_mode == 0);
      wait_done();
      rdy_mode = 0;
    end

    // Reset mid-stream.
    do_clear();
    load(s2q("1abc2\n"));
    start = 1'b1;
    step();
    start = 1'b0;
    begin
      int i;
      for (i = 0; i < 10 && !sol_input_valid; i++) step();
      chk("reached_stream", 64'(sol_input_valid), 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_sol_rst_n", 64'(sol_rst_n), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd0);
    chk("midrun_byte_count", 64'(byte_count), 64'd0);
    chk("midrun_done", 64'(done), 64'd0);
    chk("midrun_valid", 64'(sol_input_valid), 64'd0);
    chk("midrun_load_ready", 64'(load_ready), 64'd1);
    step();

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aoc_run_ctrl.md
# aoc_run_ctrl

Run controller that sequences one puzzle solver datapath (byte stream in, `input_valid`/`input_ready`/`char_in`, 64-bit `result`, `output_valid`). It buffers a complete puzzle input loaded byte-by-byte, clears the solver, streams the buffer into it with a valid/ready handshake, and waits for the solver's end-of-input indication. It then captures the final sum and line count and holds them until the next run. It sits between the testbench/host loader and the solver instance.

## Interface
- `DEPTH`, 4096: input buffer capacity in bytes; power of two, ≥ 2
- `RESULT_W`, 64: width of the solver result and the captured result
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `load_valid` in 1: loader byte valid
- `load_data` in 8: loader byte
- `load_ready` out 1: buffer accepts a byte this cycle
- `start` in 1: one-cycle run request
- `clear` in 1: empty the buffer and return to IDLE
- `sol_rst_n` out 1: active-low reset to the solver
- `sol_input_valid` out 1: byte valid to the solver
- `sol_char_in` out 8: byte to the solver
- `sol_input_ready` in 1: solver accepts the byte
- `sol_result` in RESULT_W: solver running sum
- `sol_output_valid` in 1: solver end-of-input indication
- `busy` out 1: in CLEAR, STREAM or DRAIN
- `done` out 1: result captured and held
- `result` out RESULT_W: captured final sum
- `line_count` out 32: count of 0x0A bytes accepted by the solver
- `byte_count` out $clog2(DEPTH)+1: bytes currently in the buffer

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- **IDLE:**
  - `load_ready` = (`byte_count` < DEPTH).
  - A `load_valid && load_ready` cycle writes `load_data` at index `byte_count` and increments `byte_count`.
  - `start` with `byte_count` > 0 goes to CLEAR. `start` with an empty buffer is ignored.
- **CLEAR:** lasts exactly 2 cycles with `sol_rst_n`=0. Resets `rd_ptr` and `line_count` to 0, then goes to STREAM.
- **STREAM:**
  - `sol_input_valid`=1 and `sol_char_in`=buf[`rd_ptr`]; the buffer read is combinational.
  - On `sol_input_ready`, `rd_ptr` increments. `line_count` increments if the accepted byte is 0x0A.
  - When the byte at `byte_count`-1 is accepted (plus the optional appended newline), go to DRAIN.
  - `sol_char_in` is held stable while `sol_input_ready`=0.
- **DRAIN:**
  - `sol_input_valid`=0.
  - The first cycle is a guard cycle and ignores `sol_output_valid`.
  - From the second cycle on, the first cycle with `sol_output_valid`=1 captures `sol_result` into `result` and goes to DONE.
- **DONE:**
  - `done`=1; `result` and `line_count` are held.
  - `start` re-runs the same buffer (goes to CLEAR; `done` and `result` are cleared on entry to CLEAR).
  - `clear` goes to IDLE with `byte_count`=0.
- `clear` is honoured only in IDLE and DONE. In IDLE it zeroes `byte_count`; `clear` and `start` in the same cycle means `clear` wins.
- `load_ready`=0 outside IDLE. Load bytes offered then are not accepted.
- `start` in CLEAR, STREAM or DRAIN is ignored.
- `sol_rst_n` = 0 while `rst`=1 or in CLEAR, else 1.
- `line_count` saturates at 2^32-1.

## Timing
- Reset values:
  - State IDLE.
  - `load_ready`=1, `sol_rst_n`=0, `sol_input_valid`=0, `sol_char_in`=0.
  - `busy`=0, `done`=0, `result`=0, `line_count`=0, `byte_count`=0.
  - Buffer contents are undefined.
- Reset mid-run aborts immediately: the next cycle is IDLE with an empty buffer.
- `start` sampled at cycle T:
  - T+1 and T+2 are CLEAR.
  - The first byte is presented at T+3.
- With `sol_input_ready` always 1 and N bytes streamed, `done` rises at T+N+5. Each ready-low cycle adds one cycle.
- The captured `result` equals the solver value after its last newline update.

## Configuration
- `AOC_RUN_AUTO_NEWLINE_EN`:
  - When defined: if the last buffered byte is not 0x0A, STREAM presents one extra 0x0A byte after the buffer (counted in `line_count`), then goes to DRAIN. Latency grows by 1 cycle in that case.
  - When undefined: the buffer is streamed verbatim and a trailing partial line is not summed by the solver.

## Test plan
- Load "1abc2\n" (6 bytes), `start`, ready=1 → `done` at T+11, `result`=12, `line_count`=1.
- Load "two1nine\neightwo3\n", `start` → `result`=112 (29+83), `line_count`=2.
- Load "7pqr\n3x" (no trailing newline):
  - With `AOC_RUN_AUTO_NEWLINE_EN` → `result`=110, `line_count`=2.
  - Without it → `result`=77, `line_count`=1.
- DEPTH=8: offer 9 bytes → `load_ready` falls after the 8th, `byte_count`=8, 9th byte not written. `start` on an empty buffer → stays IDLE, `busy`=0.
- Toggle `sol_input_ready` 1/0 each cycle on "1abc2\n" → `sol_char_in` stable while stalled, `result`=12. `start` again in DONE → `sol_rst_n` low for 2 cycles, `result`=12 again (not 24).
- Assert `rst` mid-STREAM → next cycle IDLE, `byte_count`=0, `done`=0, `sol_input_valid`=0, `sol_rst_n`=0 during reset.
